// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcodes, instruction field positions, loader FSM states.
package simplerisc_pkg;

    // Opcodes (bits [31:27] of every instruction word)
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    // Field bit positions
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned I_BIT   = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_LSB = 14;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned IMM_W   = 18;
    localparam int unsigned OFF_W   = 27;

    // Loader FSM states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Opcodes 21..31 are unassigned
    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_RET;
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry first-word-fall-through FIFO with synchronous flush.
module instr_fifo2 #(
    parameter int unsigned Width = 41
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign valid_o = !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed only when the head leaves in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; flush wins over everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = !wr_ptr_q;
            if (do_pop)  rd_ptr_d = !rd_ptr_q;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_encode.sv
// Packs SimpleRISC field bundles into 32-bit words and streams them to imem with addresses.
module instruction_encode
    import simplerisc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic              in_imm_en,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [17:0]       in_imm,
    input  logic [26:0]       in_off,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err_illegal,
    output logic              done
);

    localparam int unsigned       EntryW   = 32 + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [31:0]       enc;
    logic              legal, accept, push, pop;
    logic              fifo_valid, fifo_full, fifo_empty;
    logic [EntryW-1:0] fifo_wdata, fifo_rdata;

    assign legal      = op_is_legal(in_op);
    assign in_ready   = (state_q == ST_RUN) && !fifo_full && !clear;
    assign accept     = in_valid && in_ready;
    assign push       = accept && legal;
    assign pop        = fifo_valid && out_ready;
    assign fifo_wdata = {enc, addr_q, in_last};

    // Encode mux: every field not used by the opcode stays zero
    always_comb begin
        enc = '0;
        enc[OP_MSB -: OP_W] = in_op;
        case (in_op)
            OP_NOP, OP_RET: ;
            OP_BEQ, OP_BGT, OP_B, OP_CALL: enc[OFF_W-1:0] = in_off;
            default: begin
                enc[I_BIT] = in_imm_en;
                if (in_op != OP_CMP) enc[RD_LSB +: REG_W] = in_rd;
                if (in_op != OP_NOT && in_op != OP_MOV) enc[RS1_LSB +: REG_W] = in_rs1;
                if (in_imm_en) enc[IMM_W-1:0] = in_imm;
                else           enc[RS2_LSB +: REG_W] = in_rs2;
            end
        endcase
    end

    // Address counter, sticky illegal flag and load-complete FSM next-state
    always_comb begin
        addr_d  = addr_q;
        err_d   = err_q;
        state_d = state_q;
        if (clear) begin
            addr_d  = BaseAddr;
            err_d   = 1'b0;
            state_d = ST_RUN;
        end else begin
            if (push) addr_d = addr_q + ADDR_W'(1);
            if (accept && !legal) err_d = 1'b1;
            case (state_q)
                ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
                ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= BaseAddr;
            err_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            addr_q  <= addr_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    instr_fifo2 #(
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (clear),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Idle outputs read as zero; out_addr then shows the next address to be written
    assign out_valid   = fifo_valid;
    assign out_instr   = fifo_valid ? fifo_rdata[EntryW-1 -: 32] : 32'h0;
    assign out_addr    = fifo_valid ? fifo_rdata[ADDR_W:1] : addr_q;
    assign out_last    = fifo_valid && fifo_rdata[0];
    assign err_illegal = err_q;
    assign done        = (state_q == ST_DONE);

endmodule

// File: doc/instruction_encode.md
Name: instruction_encode

Overview:
- Inverse of the instruction decoder: packs opcode and register/immediate/offset fields into 32-bit SimpleRISC instruction words.
- Streams the words, each tagged with a sequential instruction-memory address, to the imem write port.
- Used by the boot/program loader and by testbenches to build programs that feed the pipeline and hazard unit.
- Field-level valid/ready input, 2-entry output FIFO, address counter, load-complete FSM.

Parameters:
ADDR_W, 8, width of the imem word address
BASE_ADDR, 0, address of the first word after reset or clear

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clear  in  1  synchronous restart: flush FIFO, reload address, clear err, FSM to RUN
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_op  in  5  opcode, same encoding as the decoder
in_imm_en  in  1  I bit: use immediate instead of rs2
in_rd  in  4  destination register
in_rs1  in  4  source 1
in_rs2  in  4  source 2
in_imm  in  18  immediate, modifier bits [17:16] plus imm16
in_off  in  27  branch/call offset
in_last  in  1  final instruction of the program
out_valid  out  1  encoded word valid
out_ready  in  1  imem write accepted
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  imem address for out_instr
out_last  out  1  this word carried in_last
err_illegal  out  1  sticky: an opcode of 21..31 was presented
done  out  1  last word drained, load complete

Behaviour:
- Reset (rst=0, async): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_last=0, err_illegal=0, done=0, FSM=RUN, address counter=BASE_ADDR.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (FSM==RUN) & FIFO not full & !clear.
- Encoding, combinational at the input. All unused bits are forced to 0.
  - Ops 0-4, 6, 7, 10-12, 14, 15: [31:27]=op, [26]=I, [25:22]=rd, [21:18]=rs1, [17:0] = I ? imm : {rs2, 14'b0}.
  - Op 5 (cmp): same as above with [25:22]=0.
  - Ops 8, 9 (not, mov): [21:18]=0, otherwise as above.
  - Ops 13, 20 (nop, ret): [26:0]=0.
  - Ops 16-19 (branch/call): [26:0]=off.
- Illegal ops 21-31:
  - Bundle is consumed but not enqueued.
  - err_illegal=1 from the next cycle and stays set until rst or clear.
  - Address counter does not advance.
  - If in_last is also set, FSM still moves to DRAIN.
- Address: each enqueued word takes the current counter value, then the counter increments.
  - Wraps modulo 2^ADDR_W with no error.
- FIFO: depth 2, first-word-fall-through.
  - Latency: word accepted at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1) when the FIFO was empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle when full is legal: in_ready stays low that cycle, since it is computed from the pre-pop state.
  - Outputs hold stable while out_valid & !out_ready.
- FSM:
  - RUN -> DRAIN when a bundle with in_last is accepted.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE: done=1, in_ready=0.
  - From any state, clear -> RUN.
- clear:
  - Has priority over a simultaneous accept or pop; the input is not accepted and any in-flight word is discarded.
  - Next cycle: out_valid=0, address=BASE_ADDR.
- rst asserted mid-operation: all state returns to reset values immediately; pending words are lost.

Decomposition:
- Shared package `simplerisc_pkg`:
  - opcode localparams (OP_ADD=0 ... OP_RET=20);
  - field bit-position constants (OP_MSB=31, I_BIT=26, RD_LSB=22, RS1_LSB=18, RS2_LSB=14);
  - FSM state encoding.
- The decoder should be migrated to the same package.
- One sub-module: `instr_fifo2`, a 2-entry FWFT FIFO, 32+ADDR_W+1 bits wide, with sync flush.
- Encode mux and FSM stay in the top module.

Test Plan:
- add r3,r1,r2 (op 0, I=0) at reset -> out_instr=0x00C48000, out_addr=0x00, out_valid one cycle after accept.
- mov r5, imm 0x01234 (op 9, I=1, rs1=7 ignored), then beq off=0x10 -> 0x4D401234 @0x00, then 0x80000010 @0x01.
- out_ready=0, present 3 nops -> first two accepted (0x68000000 @0,1), in_ready=0 on the third until one pop.
- op 21 presented -> no word emitted, err_illegal=1 next cycle, next legal word keeps the same address. clear -> err_illegal=0.
- ADDR_W=4, BASE_ADDR=14, four words -> addresses 14, 15, 0, 1.
- ret with in_last -> 0xA0000000, out_last=1, done=1 after the pop, in_ready=0. clear -> done=0, in_ready=1, address=BASE_ADDR. rst pulsed mid-stream -> out_valid=0 asynchronously.
